// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 row receiver.
// Holds size defaults, colour bit positions and the synchroniser bus layout.
package hub75_pkg;

  localparam int DEF_WIDTH     = 64;
  localparam int DEF_ADDR_BITS = 5;

  // Colour bit positions inside out_rgb.
  localparam int R1 = 0;
  localparam int R2 = 1;
  localparam int G1 = 2;
  localparam int G2 = 3;
  localparam int B1 = 4;
  localparam int B2 = 5;
  localparam int NCOLOR = 6;

  // Bit layout of the synchronised pin bus; edge-detected pins sit at the bottom.
  localparam int SY_CLK  = 0;
  localparam int SY_LAT  = 1;
  localparam int SY_BLK  = 2;
  localparam int SY_ADDR = 3;
  localparam int SY_COL  = 8;
  localparam int SY_W    = 14;
  localparam int SY_EDGE = 2;

  typedef enum logic {
    DR_IDLE,
    DR_SEND
  } dr_state_t;

endpackage

// File: rtl/hub75_rx_if.sv
// Pixel stream leaving the receiver: one beat per column, valid/ready handshake.
// The receiver drives the master side; the pixel sink uses the slave side.
interface hub75_rx_if
  import hub75_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                 out_valid;
  logic                 out_ready;
  logic [NCOLOR-1:0]    out_rgb;
  logic [COL_W-1:0]     out_col;
  logic [ADDR_BITS-1:0] out_addr;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_rgb,
    output out_col,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_rgb,
    input  out_col,
    input  out_addr,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/hub75_sync.sv
// N-bit two-flop synchroniser; the low N_EDGE bits also get a rising-edge pulse.
// Latency: o_sync lags the pins by 2 cycles, o_rise is combinational off o_sync.
module hub75_sync #(
  parameter int N      = 14,
  parameter int N_EDGE = 2
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [N-1:0]      i_pins,
  output logic [N-1:0]      o_sync,
  output logic [N_EDGE-1:0] o_rise
);

  logic [N-1:0]      r_s1;
  logic [N-1:0]      r_s2;
  logic [N_EDGE-1:0] r_s3;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_pins;
      r_s2 <= r_s1;
      r_s3 <= r_s2[N_EDGE-1:0];
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2[N_EDGE-1:0] & ~r_s3;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-bus receiver: captures shifted rows, holds one, drains it as a pixel stream.
// Edges act 3 cycles after the pin; HUB75_RX_BLANK_STATS_EN adds the blank_cnt statistic.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic ctrl_clk,
  input  logic ctrl_lat,
  input  logic ctrl_blk,
  input  logic addr_a,
  input  logic addr_b,
  input  logic addr_c,
  input  logic addr_d,
  input  logic addr_e,
  input  logic col_r1,
  input  logic col_r2,
  input  logic col_g1,
  input  logic col_g2,
  input  logic col_b1,
  input  logic col_b2,
  hub75_rx_if.master o_pix,
  output logic err_len,
  output logic err_ovf,
`ifdef HUB75_RX_BLANK_STATS_EN
  output logic [15:0] blank_cnt,
`endif
  input  logic err_clr
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [NCOLOR-1:0] w_pin_rgb;
  logic [4:0]        w_pin_addr;
  logic [SY_W-1:0]   w_pins;
  logic [SY_W-1:0]   w_sync;
  logic [SY_EDGE-1:0] w_rise;

  always_comb begin
    w_pin_rgb     = '0;
    w_pin_rgb[R1] = col_r1;
    w_pin_rgb[R2] = col_r2;
    w_pin_rgb[G1] = col_g1;
    w_pin_rgb[G2] = col_g2;
    w_pin_rgb[B1] = col_b1;
    w_pin_rgb[B2] = col_b2;
  end

  assign w_pin_addr = {addr_e, addr_d, addr_c, addr_b, addr_a};
  assign w_pins     = {w_pin_rgb, w_pin_addr, ctrl_blk, ctrl_lat, ctrl_clk};

  hub75_sync #(
    .N      (SY_W),
    .N_EDGE (SY_EDGE)
  ) u_sync (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .i_pins (w_pins),
    .o_sync (w_sync),
    .o_rise (w_rise)
  );

  logic                 w_shift;
  logic                 w_latch;
  logic [NCOLOR-1:0]    w_rgb;
  logic [4:0]           w_addr5;
  logic [ADDR_BITS-1:0] w_addr;

  assign w_shift = w_rise[SY_CLK];
  assign w_latch = w_rise[SY_LAT];
  assign w_rgb   = w_sync[SY_COL +: NCOLOR];
  assign w_addr5 = w_sync[SY_ADDR +: 5];
  assign w_addr  = w_addr5[ADDR_BITS-1:0];

  logic [CNT_W-1:0]     r_col_cnt;
  logic [NCOLOR-1:0]    r_shbuf [WIDTH];
  logic [NCOLOR-1:0]    w_row   [WIDTH];
  logic [NCOLOR-1:0]    r_hold  [WIDTH];
  logic [ADDR_BITS-1:0] r_hold_addr;
  logic                 r_hold_full;
  logic                 r_err_len;
  logic                 r_err_ovf;

  dr_state_t            r_state;
  logic                 r_out_valid;
  logic [NCOLOR-1:0]    r_out_rgb;
  logic [COL_W-1:0]     r_out_col;
  logic [ADDR_BITS-1:0] r_out_addr;
  logic                 r_out_last;

  logic             w_shift_ok;
  logic [CNT_W-1:0] w_cnt_eff;
  logic             w_row_full;
  logic             w_drain_done;
  logic             w_hold_busy;
  logic             w_take;
  logic             w_len_set;
  logic             w_ovf_set;
  logic [COL_W-1:0] w_col_nxt;

  // A shift in the same cycle as a latch counts toward the row being latched.
  assign w_shift_ok   = w_shift && (r_col_cnt != CNT_W'(WIDTH));
  assign w_cnt_eff    = r_col_cnt + CNT_W'(w_shift_ok);
  assign w_row_full   = (w_cnt_eff == CNT_W'(WIDTH));
  assign w_drain_done = (r_state == DR_SEND) && r_out_valid && o_pix.out_ready && r_out_last;
  // A hold buffer emptying this cycle can already take the next row.
  assign w_hold_busy  = r_hold_full && !w_drain_done;
  assign w_take       = w_latch && w_row_full && !w_hold_busy;
  assign w_ovf_set    = w_latch && w_row_full && w_hold_busy;
  assign w_len_set    = (w_shift && !w_shift_ok) || (w_latch && !w_row_full);
  assign w_col_nxt    = r_out_col + COL_W'(1);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_row[i] = (w_shift_ok && (r_col_cnt == CNT_W'(i))) ? w_rgb : r_shbuf[i];
    end
  end

  always_ff @(posedge in_clk) begin
    r_shbuf <= w_row;
    if (w_take) begin
      r_hold <= w_row;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_col_cnt   <= '0;
      r_hold_addr <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_latch) begin
        r_col_cnt <= '0;
      end else if (w_shift_ok) begin
        r_col_cnt <= r_col_cnt + CNT_W'(1);
      end

      if (w_take) begin
        r_hold_addr <= w_addr;
        r_hold_full <= 1'b1;
      end else if (w_drain_done) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  // Setting beats clearing when both happen in one cycle.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_err_len <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_err_len <= (r_err_len & ~err_clr) | w_len_set;
      r_err_ovf <= (r_err_ovf & ~err_clr) | w_ovf_set;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state     <= DR_IDLE;
      r_out_valid <= 1'b0;
      r_out_rgb   <= '0;
      r_out_col   <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        DR_IDLE: begin
          if (r_hold_full) begin
            r_state     <= DR_SEND;
            r_out_valid <= 1'b1;
            r_out_col   <= '0;
            r_out_rgb   <= r_hold[0];
            r_out_addr  <= r_hold_addr;
            r_out_last  <= (WIDTH == 1);
          end
        end
        DR_SEND: begin
          if (o_pix.out_ready) begin
            if (r_out_last) begin
              r_state     <= DR_IDLE;
              r_out_valid <= 1'b0;
            end else begin
              r_out_col  <= w_col_nxt;
              r_out_rgb  <= r_hold[w_col_nxt];
              r_out_last <= (w_col_nxt == COL_W'(WIDTH - 1));
            end
          end
        end
        default: begin
          r_state     <= DR_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_pix.out_valid = r_out_valid;
  assign o_pix.out_rgb   = r_out_rgb;
  assign o_pix.out_col   = r_out_col;
  assign o_pix.out_addr  = r_out_addr;
  assign o_pix.out_last  = r_out_last;
  assign err_len         = r_err_len;
  assign err_ovf         = r_err_ovf;

`ifdef HUB75_RX_BLANK_STATS_EN
  logic [15:0] r_blank_acc;
  logic [15:0] r_hold_blank;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_blank_acc  <= '0;
      r_hold_blank <= '0;
    end else begin
      if (w_latch) begin
        r_blank_acc <= '0;
      end else if (w_sync[SY_BLK] && (r_blank_acc != 16'hFFFF)) begin
        r_blank_acc <= r_blank_acc + 16'd1;
      end
      if (w_take) begin
        r_hold_blank <= r_blank_acc;
      end
    end
  end

  assign blank_cnt = (r_state == DR_SEND) ? r_hold_blank : 16'd0;
`endif

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 Parameter WIDTH, default 64: columns shifted per row.
REQ-002 Parameter ADDR_BITS, default 5: row-address width (A..E).
REQ-003 in_clk  input  1  system clock; the design has one clock, and all logic is on its rising edge.
REQ-004 in_rst  input  1  reset, synchronous, active-high.
REQ-005 ctrl_clk, ctrl_lat, ctrl_blk  input  1 each  HUB75 shift clock, latch and blank pins.
REQ-006 addr_a..addr_e  input  1 each  row address; addr_a is the LSB.
REQ-007 col_r1, col_r2, col_g1, col_g2, col_b1, col_b2  input  1 each  colour data pins.
REQ-008 out_valid  output  1  a pixel is presented.
REQ-009 out_ready  input  1  the sink accepts the pixel.
REQ-010 out_rgb  output  6  {b2,b1,g2,g1,r2,r1}; r1 is bit 0.
REQ-011 out_col  output  log2(WIDTH)  column index; column 0 is the first pixel shifted in.
REQ-012 out_addr  output  ADDR_BITS  row address captured at the latch.
REQ-013 out_last  output  1  marks column WIDTH-1.
REQ-014 err_len, err_ovf  output  1 each  sticky error flags.
REQ-015 err_clr  input  1  clears both error flags.

Function
REQ-016 Synchronisation:
- Every bus pin SHALL pass through an identical 2-flop synchroniser.
- A ctrl_clk or ctrl_lat rising edge SHALL be acted on 3 in_clk cycles after the pin edge.
REQ-017 Input timing: each ctrl_clk level SHALL be accepted if it is held for at least 1 in_clk cycle.
REQ-018 Shifting, on each synchronised ctrl_clk rising edge:
- The 6 synchronised colour bits SHALL be written into shift-buffer slot col_cnt.
- col_cnt SHALL then increment, saturating at WIDTH.
REQ-019 Latch, on each synchronised ctrl_lat rising edge:
- If col_cnt==WIDTH and the hold buffer is empty, the shift buffer and address SHALL copy into the hold buffer, which becomes full.
- col_cnt SHALL reset to 0 in every case.
REQ-020 Length error: a latch edge with col_cnt!=WIDTH SHALL set err_len and discard the row.
- A shift edge with col_cnt==WIDTH SHALL also set err_len; that data is dropped.
REQ-021 Overflow: a latch edge with col_cnt==WIDTH while the hold buffer is full SHALL set err_ovf.
- The new row SHALL be dropped, and the held row SHALL be unchanged.
REQ-022 Drain FSM states:
- DR_IDLE goes to DR_SEND when the hold buffer becomes full.
- DR_SEND goes to DR_IDLE when the out_last beat is accepted; the hold buffer then becomes empty.
REQ-023 Drain output:
- In DR_SEND, out_valid SHALL be 1.
- out_col SHALL count 0..WIDTH-1 and advance only on out_valid&&out_ready.
- While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-024 First-pixel latency: out_valid SHALL rise 1 cycle after the hold buffer becomes full.
REQ-025 Streaming row: a row latched while the hold buffer empties in the same cycle SHALL be accepted, not flagged.
REQ-026 Simultaneous edges: shift and latch edges in the same cycle SHALL process the shift first, then the latch.
REQ-027 Error clearing:
- err_clr SHALL clear both flags.
- A set condition in the same cycle SHALL win.
REQ-028 ctrl_blk SHALL NOT affect data capture.

Reset
REQ-029 When in_rst=1, the following SHALL reset:
- out_valid=0, out_rgb=0, out_col=0, out_addr=0, out_last=0.
- err_len=0, err_ovf=0.
- col_cnt=0, hold buffer empty, FSM in DR_IDLE, synchronisers=0.
REQ-030 Reset mid-row or mid-drain SHALL discard all partial and held data; no edge SHALL be detected in the first cycle after reset.

Configuration
REQ-031 With HUB75_RX_BLANK_STATS_EN defined:
- Output blank_cnt [15:0] SHALL count cycles with synchronised ctrl_blk=1 between latch edges, saturating at 16'hFFFF.
- The count SHALL copy into the hold buffer on a successful latch and drive blank_cnt during DR_SEND.
- The counter SHALL clear on every latch edge.
REQ-032 Without HUB75_RX_BLANK_STATS_EN, port blank_cnt and its logic SHALL be absent.

Structure
REQ-033 Package hub75_pkg SHALL hold:
- WIDTH and ADDR_BITS defaults.
- Colour bit-index constants R1=0, R2=1, G1=2, G2=3, B1=4, B2=5.
- The drain-state enum.
REQ-034 Sub-module hub75_sync SHALL be used: an N-bit 2-flop synchroniser plus rising-edge detect, instanced once for all bus pins.

Verification
REQ-035 Nominal row: 64 clocks of colour 6'b010101, latch, address 5'd7, out_ready=1 -> 64 beats with out_rgb=6'h15, out_addr=7, out_last at col 63, and no error flags.
REQ-036 Short row: 63 clocks then latch -> err_len=1 and out_valid stays 0; err_clr pulse -> err_len=0.
REQ-037 Overflow: two full rows latched while out_ready=0 -> err_ovf=1; releasing out_ready drains only the first row's data and address.
REQ-038 Backpressure: toggle out_ready every cycle -> exactly 64 accepted beats, in order, with outputs stable while stalled.
REQ-039 Reset: assert in_rst at col_cnt=30 -> all outputs reset; a subsequent full row is received correctly.
REQ-040 Blank stats (macro defined): ctrl_blk high for 100 cycles within a row -> blank_cnt=100 during that row's drain.
